// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the memory_ram access arbiter
package ram_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        CAP  = 2'd3
    } state_t;

    // Owner id of the access currently in flight.
    localparam logic OWN_CORE   = 1'b0;
    localparam logic OWN_PERIPH = 1'b1;

endpackage

// File: rtl/ram_prio_arb.sv
// rtl/ram_prio_arb.sv - core/peripheral winner selection with optional starvation guard
//
// Purpose: picks which requester owns the next memory_ram access. The core has
//          fixed priority. With STARVE_GUARD_EN defined, a 4-bit counter tracks
//          consecutive core grants taken while the peripheral was waiting; once
//          it reaches MAX_WAIT the peripheral wins the next arbitration.
// Ports:
//   clock, reset  clock and async active-high reset (STARVE_GUARD_EN only)
//   i_arb_en      arbitration allowed this cycle (sequencer idle)
//   i_c_req       core request
//   i_p_req       peripheral request
//   o_grant       a winner is selected this cycle
//   o_owner       winner id (OWN_CORE / OWN_PERIPH)
// Macro: STARVE_GUARD_EN
module ram_prio_arb
`ifdef STARVE_GUARD_EN
#(
    parameter int MAX_WAIT = 4
)
`endif
(
`ifdef STARVE_GUARD_EN
    input  logic clock,
    input  logic reset,
`endif
    input  logic i_arb_en,
    input  logic i_c_req,
    input  logic i_p_req,
    output logic o_grant,
    output logic o_owner
);
    import ram_arb_pkg::*;

    assign o_grant = i_arb_en & (i_c_req | i_p_req);

`ifdef STARVE_GUARD_EN
    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_wait;
    logic       w_force_p;

    assign w_force_p = (r_wait == LP_MAX_WAIT);

    always_comb begin
        o_owner = OWN_CORE;
        if (i_p_req && (!i_c_req || w_force_p)) begin
            o_owner = OWN_PERIPH;
        end
    end

    // Only evaluated while the sequencer is idle, so each grant counts once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait <= 4'd0;
        end else if (i_arb_en) begin
            if (o_grant && (o_owner == OWN_PERIPH)) begin
                r_wait <= 4'd0;
            end else if (o_grant && i_p_req) begin
                r_wait <= r_wait + 4'd1;
            end else if (!i_p_req) begin
                r_wait <= 4'd0;
            end
        end
    end
`else
    always_comb begin
        o_owner = OWN_CORE;
        if (i_p_req && !i_c_req) begin
            o_owner = OWN_PERIPH;
        end
    end
`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - two-requester arbiter and strobe sequencer for memory_ram
//
// Purpose: arbitrates the core (c_*) and peripheral (p_*) ports onto the single
//          memory_ram port, generates the rd/wr strobes, captures read data and
//          returns a one-cycle done pulse to the owner.
// Ports:
//   clock, reset                      clock, async active-high reset
//   c_req..c_indirect / c_gnt..c_rbit core request fields and response
//   p_req..p_bit_in   / p_gnt..p_rbit peripheral request fields and response
//   m_addr..m_indirect_flag           drive memory_ram
//   m_out, m_out_bit                  read data from memory_ram
//   busy                              sequencer not idle
// Parameters: RD_LAT (1..4), MAX_WAIT (1..15, STARVE_GUARD_EN only)
// Macro: STARVE_GUARD_EN
module ram_access_arbiter #(
    parameter int RD_LAT = 1
`ifdef STARVE_GUARD_EN
    ,
    parameter int MAX_WAIT = 4
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       c_req,
    input  logic       c_wr,
    input  logic [7:0] c_addr,
    input  logic [7:0] c_wdata,
    input  logic       c_is_bit,
    input  logic [7:0] c_bit_addr,
    input  logic       c_bit_in,
    input  logic       c_indirect,
    output logic       c_gnt,
    output logic       c_done,
    output logic [7:0] c_rdata,
    output logic       c_rbit,
    input  logic       p_req,
    input  logic       p_wr,
    input  logic [7:0] p_addr,
    input  logic [7:0] p_wdata,
    input  logic       p_is_bit,
    input  logic [7:0] p_bit_addr,
    input  logic       p_bit_in,
    output logic       p_gnt,
    output logic       p_done,
    output logic [7:0] p_rdata,
    output logic       p_rbit,
    output logic [7:0] m_addr,
    output logic [7:0] m_in_data,
    output logic [7:0] m_bit_addr,
    output logic       m_rd,
    output logic       m_wr,
    output logic       m_in_bit,
    output logic       m_is_bit,
    output logic       m_indirect_flag,
    input  logic [7:0] m_out,
    input  logic       m_out_bit,
    output logic       busy
);
    import ram_arb_pkg::*;

    // RD holds for RD_LAT cycles: load RD_LAT-1 and leave when it reaches zero.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [ADDR_W-1:0]   r_bit_addr;
    logic                r_is_bit;
    logic                r_bit_in;
    logic                r_ind;
    logic [1:0]          r_lat;
    logic                r_c_gnt, r_p_gnt, r_c_done, r_p_done;
    logic [DATA_W-1:0]   r_c_rdata, r_p_rdata;
    logic                r_c_rbit, r_p_rbit;

    logic                w_idle, w_grant, w_owner;
    logic                w_sel_wr, w_sel_is_bit, w_sel_bit_in, w_sel_ind;
    logic [ADDR_W-1:0]   w_sel_addr, w_sel_bit_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_m_rd, w_m_wr, w_busy, w_fin;

    assign w_idle = (r_state == IDLE);

    ram_prio_arb
`ifdef STARVE_GUARD_EN
    #(.MAX_WAIT(MAX_WAIT))
`endif
    u_prio_arb (
`ifdef STARVE_GUARD_EN
        .clock    (clock),
        .reset    (reset),
`endif
        .i_arb_en (w_idle),
        .i_c_req  (c_req),
        .i_p_req  (p_req),
        .o_grant  (w_grant),
        .o_owner  (w_owner)
    );

    // Winner's request fields; the peripheral has no indirect input.
    always_comb begin
        w_sel_wr       = c_wr;
        w_sel_addr     = c_addr;
        w_sel_wdata    = c_wdata;
        w_sel_is_bit   = c_is_bit;
        w_sel_bit_addr = c_bit_addr;
        w_sel_bit_in   = c_bit_in;
        w_sel_ind      = c_indirect;
        if (w_owner == OWN_PERIPH) begin
            w_sel_wr       = p_wr;
            w_sel_addr     = p_addr;
            w_sel_wdata    = p_wdata;
            w_sel_is_bit   = p_is_bit;
            w_sel_bit_addr = p_bit_addr;
            w_sel_bit_in   = p_bit_in;
            w_sel_ind      = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_rd      = 1'b0;
        w_m_wr      = 1'b0;
        w_busy      = 1'b1;
        w_fin       = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_grant) begin
                    w_state_nxt = w_sel_wr ? WR : RD;
                end
            end
            WR: begin
                w_m_wr      = 1'b1;
                w_fin       = 1'b1;
                w_state_nxt = IDLE;
            end
            RD: begin
                w_m_rd = 1'b1;
                if (r_lat == 2'd0) begin
                    w_state_nxt = CAP;
                end
            end
            CAP: begin
                w_m_rd      = 1'b1;
                w_fin       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner    <= OWN_CORE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_bit_addr <= '0;
            r_is_bit   <= 1'b0;
            r_bit_in   <= 1'b0;
            r_ind      <= 1'b0;
            r_lat      <= 2'd0;
            r_c_gnt    <= 1'b0;
            r_p_gnt    <= 1'b0;
            r_c_done   <= 1'b0;
            r_p_done   <= 1'b0;
            r_c_rdata  <= '0;
            r_c_rbit   <= 1'b0;
            r_p_rdata  <= '0;
            r_p_rbit   <= 1'b0;
        end else begin
            r_c_gnt  <= w_grant && (w_owner == OWN_CORE);
            r_p_gnt  <= w_grant && (w_owner == OWN_PERIPH);
            // Done lands in the idle cycle after the last strobe cycle.
            r_c_done <= w_fin && (r_owner == OWN_CORE);
            r_p_done <= w_fin && (r_owner == OWN_PERIPH);
            if (w_grant) begin
                r_owner    <= w_owner;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
                r_bit_addr <= w_sel_bit_addr;
                r_is_bit   <= w_sel_is_bit;
                r_bit_in   <= w_sel_bit_in;
                r_ind      <= w_sel_ind;
                r_lat      <= LAT_LOAD;
            end else if ((r_state == RD) && (r_lat != 2'd0)) begin
                r_lat <= r_lat - 2'd1;
            end
            if (r_state == CAP) begin
                if (r_owner == OWN_CORE) begin
                    r_c_rdata <= m_out;
                    r_c_rbit  <= m_out_bit;
                end else begin
                    r_p_rdata <= m_out;
                    r_p_rbit  <= m_out_bit;
                end
            end
        end
    end

    assign c_gnt           = r_c_gnt;
    assign c_done          = r_c_done;
    assign c_rdata         = r_c_rdata;
    assign c_rbit          = r_c_rbit;
    assign p_gnt           = r_p_gnt;
    assign p_done          = r_p_done;
    assign p_rdata         = r_p_rdata;
    assign p_rbit          = r_p_rbit;
    assign m_addr          = r_addr;
    assign m_in_data       = r_wdata;
    assign m_bit_addr      = r_bit_addr;
    assign m_in_bit        = r_bit_in;
    assign m_is_bit        = r_is_bit;
    assign m_indirect_flag = r_ind;
    assign m_rd            = w_m_rd;
    assign m_wr            = w_m_wr;
    assign busy            = w_busy;

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Two-requester controller for the single port of memory_ram (internal RAM/SFR/bit space).
- Arbitrates between the CPU core port (c_*) and the peripheral SFR-update port (p_*, e.g. timer/serial flag updates).
- Sequences each access into correctly timed rd/wr strobes and captures read data.
- Returns a completion pulse to the requester.
- Sits between the core/peripherals and memory_ram; it is the only driver of the RAM port.

Parameters:
RD_LAT, 1, cycles memory_ram needs from rd asserted until out/out_bit are valid (1..4).
MAX_WAIT, 4, consecutive core grants tolerated while p_req pending (used only with STARVE_GUARD_EN; 1..15).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
c_req  in  1  core access request; hold with fields stable until c_gnt.
c_wr  in  1  1 = write, 0 = read.
c_addr  in  8  byte address.
c_wdata  in  8  write byte.
c_is_bit  in  1  bit-addressed access.
c_bit_addr  in  8  bit address.
c_bit_in  in  1  bit write value.
c_indirect  in  1  indirect-addressing flag (upper 128 bytes).
c_gnt  out  1  one-cycle accept pulse.
c_done  out  1  one-cycle completion pulse.
c_rdata  out  8  read byte, valid with c_done on reads; held until next core read completes.
c_rbit  out  1  read bit, same timing as c_rdata.
p_req, p_wr, p_addr[8], p_wdata[8], p_is_bit, p_bit_addr[8], p_bit_in  in  peripheral request; same meaning as the c_* equivalents, no indirect input.
p_gnt, p_done, p_rdata[8], p_rbit  out  peripheral response; same meaning as the c_* equivalents.
m_addr, m_in_data, m_bit_addr  out  8 each  to memory_ram.
m_rd, m_wr, m_in_bit, m_is_bit, m_indirect_flag  out  1 each  to memory_ram.
m_out  in  8  from memory_ram.
m_out_bit  in  1  from memory_ram.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state IDLE; all outputs 0; rdata/rbit registers 0; starvation counter 0. Reset mid-transaction aborts it: strobes drop immediately, no done pulse is issued, nothing is retried.
- FSM states: IDLE, WR, RD, CAP.
- IDLE: requests are sampled only in IDLE.
  - Both requesting: core wins (fixed priority).
  - On a winner: latch all fields plus owner id; next state is WR if wr=1, else RD; winner's gnt is high for exactly the next cycle.
  - m_indirect_flag is the latched c_indirect for core and 0 for peripheral.
- WR: m_wr=1 for exactly 1 cycle with latched fields; next state IDLE; owner's done pulses in the IDLE cycle that follows.
- RD: m_rd=1 for RD_LAT cycles (down-counter); next state CAP.
- CAP: m_rd stays 1; capture m_out/m_out_bit into owner's rdata/rbit at the end of this cycle; next state IDLE; done pulses in the following cycle.
- Latency from req sampled (cycle 0):
  - gnt: cycle 1.
  - Write: done at cycle 2.
  - Read: done at cycle RD_LAT+2.
  - Back-to-back writes: 1 per 2 cycles.
- Requester handshake: deassert req on the edge where gnt is seen. req still high in a later IDLE cycle is a new request. Fields may change after gnt.
- m_* data/address fields hold their last latched values when idle; m_rd and m_wr are 0 outside WR/RD/CAP. m_rd and m_wr are never high together.
- The non-owner requester's response outputs are untouched. c_gnt and p_gnt are never high together; the same holds for c_done/p_done.
- Addresses and bit addresses pass through unmodified; there are no range checks.

Optional Feature:
STARVE_GUARD_EN:
- Defined: a 4-bit counter increments on each core grant while p_req=1. It clears on a peripheral grant, or in any IDLE cycle with p_req=0. When counter==MAX_WAIT, the next arbitration grants the peripheral even if c_req=1.
- Undefined: pure fixed core priority; counter logic absent.

Decomposition:
- Package ram_arb_pkg: state enum (IDLE/WR/RD/CAP), owner id constants (OWN_CORE=0, OWN_PERIPH=1), width constants ADDR_W=8, DATA_W=8.
- One sub-module, ram_prio_arb: combinational winner selection plus the starvation counter (under STARVE_GUARD_EN).
- The FSM, field latch and response capture stay in the top module.

Test Plan:
- Core write 8'h18 to 8'h88, c_req at cycle 0 -> c_gnt cycle 1; m_wr=1, m_addr=88, m_in_data=18 in cycle 1; c_done cycle 2; p_* outputs stay 0.
- Then core read 8'h88 (RD_LAT=1) -> m_rd high cycles 1-2, c_done cycle 3 with c_rdata=8'h18.
- Core bit write bit_addr 8'h05, bit_in=1, then bit read of 8'h05 -> m_is_bit=1 during both accesses, c_rbit=1 with c_done.
- c_req and p_req writes together at cycle 0 -> c_gnt 1, c_done 2, p_gnt 3, p_done 4; m_indirect_flag=0 during the peripheral access.
- Reset asserted during RD -> m_rd=0 in the same cycle, no c_done; after release, a new core read completes normally.
- STARVE_GUARD_EN, MAX_WAIT=2, c_req held high, p_req held high -> p_gnt after exactly 2 c_gnt pulses. Without the macro, no p_gnt until c_req drops.
